// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the mux select sequencer: FSM state
// encoding, channel count, select width and a one-hot helper.
package mux_seq_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  // Expands a channel index into a one-hot channel mask.
  function automatic logic [NUM_CH-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_CH-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational next-requester finder for the mux select sequencer.
// Default build: round-robin search starting at ptr+1 and wrapping modulo 4,
// so the channel granted last has the lowest priority.
// With MUXSEQ_FIXED_PRIO_EN defined: lowest-index requester wins and ptr is
// ignored.
module rr_pick
  import mux_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  idx,
  output logic              found
);

`ifdef MUXSEQ_FIXED_PRIO_EN

  // Fixed priority: scan downward so the lowest requesting index is kept last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

`else

  logic [SEL_W-1:0] cand;

  // Round-robin: first requester found at ptr+1, ptr+2, ... ptr+4 (== ptr).
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/mux_sel_sequencer.sv
// Round-robin channel sequencer driving the {s1,s0} selects of a 4:1 mux.
// Grants one requesting channel, holds the select for dwell+1 cycles so the
// mux output settles, raises sample_valid and waits for ack before moving on.
// Optional build macro MUXSEQ_FIXED_PRIO_EN switches the channel choice to
// fixed priority (channel 0 highest); all timing is unchanged.
module mux_sel_sequencer #(
  parameter int DWELL_W = 4,
  parameter int NUM_CH  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_CH-1:0]  req,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               ack,
  output logic               s1,
  output logic               s0,
  output logic [NUM_CH-1:0]  grant,
  output logic               sample_valid,
  output logic               busy,
  output logic               done
);

  import mux_seq_pkg::*;

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] cnt;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_found;

  rr_pick u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // The select register drives the mux directly; it only changes on grant.
  assign s1 = sel[1];
  assign s0 = sel[0];

  // Sequencer FSM: grant in IDLE, settle in HOLD, handshake in WAIT_ACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= SEL_W'(NUM_CH - 1);
      sel          <= '0;
      cnt          <= '0;
      grant        <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en && pick_found) begin
            sel   <= pick_idx;
            grant <= idx_to_onehot(pick_idx);
            cnt   <= dwell;
            busy  <= 1'b1;
            state <= HOLD;
          end else begin
            grant <= '0;
          end
        end
        HOLD: begin
          // A zero count on entry still costs one HOLD cycle.
          if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else begin
            sample_valid <= 1'b1;
            state        <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack) begin
            ptr          <= sel;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            grant        <= '0;
            done         <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Self-checking bench for mux_sel_sequencer: transaction-level reference
// model of channel choice and handshake timing, randomized traffic.
module tb_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] dwell;
  logic       ack;
  logic       s1, s0;
  logic [3:0] grant;
  logic       sample_valid, busy, done;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         last_ch = 3;
  logic [1:0] exp_sel = 2'd0;

  always #5 clk = ~clk;

  mux_sel_sequencer #(.DWELL_W(4), .NUM_CH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .req          (req),
    .dwell        (dwell),
    .ack          (ack),
    .s1           (s1),
    .s0           (s0),
    .grant        (grant),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] e_sel, input logic [3:0] e_grant,
                           input logic e_sv, input logic e_busy, input logic e_done);
    check_val({tag, ".sel"},   {30'd0, s1, s0}, {30'd0, e_sel});
    check_val({tag, ".grant"}, {28'd0, grant},  {28'd0, e_grant});
    check_val({tag, ".valid"}, {31'd0, sample_valid}, {31'd0, e_sv});
    check_val({tag, ".busy"},  {31'd0, busy},   {31'd0, e_busy});
    check_val({tag, ".done"},  {31'd0, done},   {31'd0, e_done});
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Which channel should be served next, given the requests and the last served channel.
  function automatic int ref_pick(input logic [3:0] rq, input int last);
`ifdef MUXSEQ_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) if (rq[i]) return i;
`else
    for (int k = 1; k <= 4; k++) if (rq[(last + k) % 4]) return (last + k) % 4;
`endif
    return -1;
  endfunction

  // mode 0: quiet HOLD, 1: random input noise in HOLD, 2: req dropped + early ack in HOLD
  task automatic run_txn(input logic [3:0] rq, input int dw, input int wait_n, input int mode);
    int         ch;
    logic [3:0] oh;
    en = 1'b1; req = rq; dwell = dw[3:0]; ack = 1'b0;
    ch = ref_pick(rq, last_ch);
    oh = 4'b0001 << ch;
    exp_sel = ch[1:0];
    tick;
    check_all("grant", exp_sel, oh, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i <= dw; i++) begin
      if (mode == 1) begin
        req = 4'($urandom); dwell = 4'($urandom); en = 1'($urandom); ack = 1'($urandom);
      end else if (mode == 2) begin
        req = 4'b0000; en = 1'b0; ack = 1'b1;
      end
      tick;
      if (i < dw) check_all("hold", exp_sel, oh, 1'b0, 1'b1, 1'b0);
      else        check_all("wait_entry", exp_sel, oh, 1'b1, 1'b1, 1'b0);
    end
    ack = 1'b0;
    for (int i = 0; i < wait_n; i++) begin
      tick;
      check_all("wait_hold", exp_sel, oh, 1'b1, 1'b1, 1'b0);
    end
    ack = 1'b1; en = 1'b0;
    tick;
    check_all("ack_done", exp_sel, 4'b0000, 1'b0, 1'b0, 1'b1);
    last_ch = ch;
    ack = 1'b0;
    tick;
    check_all("post_done", exp_sel, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  // IDLE must ignore stray acks and must not grant without both en and a request.
  task automatic idle_check;
    en = 1'b1; req = 4'b0000; ack = 1'b1;
    tick;
    check_all("idle_noreq", exp_sel, 4'b0000, 1'b0, 1'b0, 1'b0);
    en = 1'b0; req = 4'($urandom_range(1, 15));
    tick;
    check_all("idle_noen", exp_sel, 4'b0000, 1'b0, 1'b0, 1'b0);
    ack = 1'b0;
  endtask

  initial begin
    int         got;
    int         ch;
    logic [3:0] prev;
    logic [3:0] rq;

    // Reset with all channels requesting
    rst_n = 1'b0; en = 1'b1; req = 4'b1111; dwell = 4'd0; ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick;
    check_all("idle_after_reset", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Single channel 2 with dwell 3
    run_txn(4'b0100, 3, 0, 0);
    idle_check();

    // Back-to-back service with ack held high
    en = 1'b1; req = 4'b1111; dwell = 4'd0; ack = 1'b1;
    got = 0; prev = 4'b0000;
    for (int c = 0; c < 15; c++) begin
      tick;
      if (grant != 4'b0000 && prev == 4'b0000) begin
        ch = ref_pick(4'b1111, last_ch);
        check_val("rr_seq", {28'd0, grant}, {28'd0, 4'b0001 << ch});
        last_ch = ch;
        got++;
      end
      prev = grant;
    end
    check_val("rr_count", got, 5);
    exp_sel = last_ch[1:0];
    en = 1'b0; ack = 1'b0;
    tick;
    check_all("rr_end", exp_sel, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Maximum dwell, then a HOLD with dropped requests and an early ack
    run_txn(4'($urandom_range(1, 15)), 15, 1, 0);
    run_txn(4'b1011, 2, 2, 2);
    run_txn(4'b0110, 0, 1, 2);

    // Asynchronous reset while waiting for ack
    en = 1'b1; req = 4'b0010; dwell = 4'd1; ack = 1'b0;
    repeat (3) tick;
    check_all("pre_reset_wait", 2'd1, 4'b0010, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all("async_reset", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all("in_reset", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    last_ch = 3;
    exp_sel = 2'd0;
    tick;
    check_all("after_abort", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    run_txn(4'b1000, 2, 1, 0);
    run_txn(4'b1111, 1, 0, 0);

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      rq = 4'($urandom_range(1, 15));
      run_txn(rq, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) idle_check();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
